digit_serial_adder: RTL and testbench
=====================================

Name: digit_serial_adder

Overview:
- Parametrised, sequential successor to the team's single-bit full adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock through an internal DIGIT-wide ripple chain of full-adder cells; carry is held in a register between cycles.
- Valid/ready handshake on both sides, so it drops into the datapath as a small, area-cheap arithmetic unit.
- Reports carry-out and signed overflow.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of DIGIT.
- DIGIT, 4, bits processed per cycle (1..WIDTH). N = WIDTH/DIGIT cycles per operation.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0: a+b+cin; 1: a-b-cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  raw adder carry-out (in sub mode, 1 means no borrow).
- ovf  output  1  two's-complement overflow.

Behaviour:
- Reset (async, immediate) drives state to IDLE and clears all registers.
  - Outputs during and after reset: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
  - Reset mid-RUN or mid-DONE aborts the operation; the partial result is discarded.
- FSM: IDLE -> RUN -> DONE -> IDLE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch:
    - A_sh = a.
    - B_sh = sub ? ~b : b.
    - carry = sub ? ~cin : cin.
    - digit counter = 0.
    - Go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle:
    - Add the low DIGIT bits of A_sh and B_sh plus carry.
    - Shift the DIGIT-bit result into the result register from the MSB end.
    - Shift A_sh and B_sh right by DIGIT.
    - Update carry and increment the counter.
    - On the last digit (counter==N-1), also capture cout=final carry and ovf=(carry into MSB) XOR (carry out of MSB), then go to DONE.
  - DONE: out_valid=1, in_ready=0. sum, cout and ovf are held stable. On out_ready go to IDLE.
- Latency:
  - Handshake at edge k -> out_valid high from the cycle after edge k+N.
  - DIGIT=WIDTH gives a single RUN cycle.
  - Minimum operation period is N+2 cycles. No overlap: in_ready=0 throughout RUN and DONE.
- sum, cout and ovf are registered and keep their last values after leaving DONE, until the next final digit overwrites them. During RUN they show the previous result, never partial bits; a separate working register is used.
- in_valid while in_ready=0 is ignored. Operands are sampled only at the accepting edge, so later changes to a, b, cin or sub have no effect.
- out_ready while out_valid=0 is ignored.
- Wrap-around: sum is modulo 2^WIDTH; no saturation.

Test Plan (WIDTH=16, DIGIT=4 unless stated):
- add 0xFFFF+0x0001, cin=0 -> after 4 RUN cycles out_valid=1, sum=0x0000, cout=1, ovf=0.
- add 0x7FFF+0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Add 0x1234+0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0.
- sub 0x0005-0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0. Sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, sum/cout/ovf stable, in_ready=0, in_valid pulses ignored. out_ready=1 -> in_ready=1 next cycle.
- Reset asserted 2 cycles into RUN -> outputs cleared immediately, in_ready=1. A new op 0x0001+0x0001 then yields sum=0x0002, with no residue from the aborted op.
- Parameter sweep DIGIT=1, 4 and 16 with 1000 random a/b/cin/sub each, scoreboard versus a behavioural model -> all match; RUN length is exactly 16, 4 and 1 cycles respectively.

Source files
------------

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands are consumed DIGIT bits per
// cycle through a ripple chain of full-adder cells, with valid/ready on both sides.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] dsum;
  logic [WIDTH-1:0] dsum_ext;
  logic             c_into_msb;
  logic             c_out;

  // Ripple chain over the low DIGIT bits; c_into_msb is only meaningful on the
  // last digit, where bit DIGIT-1 of the chain is the operand sign bit.
  always_comb begin
    logic c;
    c          = carry_q;
    c_into_msb = 1'b0;
    dsum       = '0;
    for (int i = 0; i < DIGIT; i++) begin
      c_into_msb = c;
      dsum[i]    = a_sh_q[i] ^ b_sh_q[i] ^ c;
      c          = (a_sh_q[i] & b_sh_q[i]) | (c & (a_sh_q[i] ^ b_sh_q[i]));
    end
    c_out = c;
  end

  always_comb begin
    dsum_ext                   = '0;
    dsum_ext[WIDTH-1 -: DIGIT] = dsum;
  end

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    work_d    = work_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Subtraction is a + ~b + ~borrow, so the adder itself never changes.
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub ? ~cin : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d  = (work_q >> DIGIT) | dsum_ext;
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        carry_d = c_out;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = work_d;
          cout_d  = c_out;
          ovf_d   = c_into_msb ^ c_out;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder at DIGIT = 1, 4 and 16 (WIDTH = 16),
// checked against an integer-arithmetic reference model.
module tb_digit_serial_adder;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  function automatic void chk(string name, int dg, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (DIGIT=%0d): got %0h, expected %0h", name, dg, act, exp);
  endfunction

  // Reference: plain unsigned and signed integer arithmetic.
  function automatic exp_t model(logic [W-1:0] xa, logic [W-1:0] xb, logic xc, logic xs, int acc);
    exp_t   e;
    longint ua, ub, sa, sb, ur, sr, lim;
    ua  = longint'(xa);
    ub  = longint'(xb);
    sa  = longint'($signed(xa));
    sb  = longint'($signed(xb));
    lim = longint'(1) << (W - 1);
    if (xs) begin
      ur     = ua - ub - longint'(xc);
      sr     = sa - sb - longint'(xc);
      e.cout = (ua >= ub + longint'(xc));
    end else begin
      ur     = ua + ub + longint'(xc);
      sr     = sa + sb + longint'(xc);
      e.cout = ((ur >> W) != 0);
    end
    e.sum = ur[W-1:0];
    e.ovf = (sr > lim - 1) || (sr < -lim);
    e.acc = acc;
    return e;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int DG = (gi == 0) ? 1 : (gi == 1) ? 4 : 16;
    localparam int N  = W / DG;

    logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;
    exp_t         sb_q[$];
    exp_t         h;
    logic [W-1:0] last_sum;
    logic         last_cout, last_ovf;
    bit           seen;
    bit           fin;

    digit_serial_adder #(.WIDTH(W), .DIGIT(DG)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
    );

    // Monitor: compares the presented result with the scoreboard head every
    // cycle it is valid, pops on acceptance, and checks held values otherwise.
    always @(negedge clk) begin
      if (!rst) begin
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_result (DIGIT=%0d): got sum %0h with empty scoreboard", DG, sum);
          end else begin
            h = sb_q[0];
            if (!seen) begin
              chk("latency", DG, 64'(cyc - h.acc), 64'(N));
              seen = 1'b1;
            end
            chk("sum", DG, 64'(sum), 64'(h.sum));
            chk("cout", DG, 64'(cout), 64'(h.cout));
            chk("ovf", DG, 64'(ovf), 64'(h.ovf));
            chk("in_ready_busy", DG, 64'(in_ready), 64'd0);
            if (out_ready) begin
              last_sum  = h.sum;
              last_cout = h.cout;
              last_ovf  = h.ovf;
              void'(sb_q.pop_front());
              seen = 1'b0;
              $display("DIGIT=%0d result sum=%04h cout=%0b ovf=%0b", DG, sum, cout, ovf);
            end
          end
        end else begin
          chk("held_sum", DG, 64'(sum), 64'(last_sum));
          chk("held_flags", DG, 64'({cout, ovf}), 64'({last_cout, last_ovf}));
        end
      end
    end

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    task automatic issue(logic [W-1:0] xa, logic [W-1:0] xb, logic xc, logic xs);
      int t;
      t        = 0;
      in_valid = 1'b1;
      a = xa; b = xb; cin = xc; sub = xs;
      while (!in_ready && t < 300) begin
        out_ready = ($urandom_range(0, 3) != 0);
        step();
        t++;
      end
      if (!in_ready) begin
        n_checks++;
        $display("FAIL accept_timeout (DIGIT=%0d): in_ready stayed 0, expected 1 within 300 cycles", DG);
      end else begin
        sb_q.push_back(model(xa, xb, xc, xs, cyc + 1));
        $display("DIGIT=%0d issue a=%04h b=%04h cin=%0b sub=%0b", DG, xa, xb, xc, xs);
      end
      step();
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic wait_done();
      int t;
      t         = 0;
      out_ready = 1'b1;
      while (sb_q.size() != 0 && t < 300) begin
        step();
        t++;
      end
      if (sb_q.size() != 0) begin
        n_checks++;
        $display("FAIL drain_timeout (DIGIT=%0d): %0d results pending, expected 0", DG, sb_q.size());
        sb_q.delete();
      end
    endtask

    logic [33:0] vecs [5] = '{
      {16'hFFFF, 16'h0001, 1'b0, 1'b0},
      {16'h7FFF, 16'h0001, 1'b0, 1'b0},
      {16'h1234, 16'h4321, 1'b1, 1'b0},
      {16'h0005, 16'h0007, 1'b0, 1'b1},
      {16'h8000, 16'h0001, 1'b0, 1'b1}
    };

    initial begin
      int t;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0; seen = 1'b0; fin = 1'b0;
      step(); step();
      chk("reset_in_ready", DG, 64'(in_ready), 64'd1);
      chk("reset_out_valid", DG, 64'(out_valid), 64'd0);
      chk("reset_outputs", DG, 64'({sum, cout, ovf}), 64'd0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 5; i++) begin
        out_ready = 1'b1;
        issue(vecs[i][33:18], vecs[i][17:2], vecs[i][1], vecs[i][0]);
        wait_done();
      end

      // Backpressure: result must hold while in_valid pulses are ignored.
      out_ready = 1'b0;
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      out_ready = 1'b0;
      t = 0;
      while (!out_valid && t < 100) begin step(); t++; end
      chk("bp_out_valid", DG, 64'(out_valid), 64'd1);
      for (int i = 0; i < 10; i++) begin
        in_valid = 1'($urandom);
        a = W'($urandom); b = W'($urandom);
        step();
        chk("bp_still_valid", DG, 64'(out_valid), 64'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("in_ready_after_done", DG, 64'(in_ready), 64'd1);
      wait_done();

      // Reset two cycles into an operation aborts it.
      out_ready = 1'b1;
      issue(16'hABCD, 16'h1357, 1'b1, 1'b0);
      step();
      rst = 1'b1;
      #1;
      chk("abort_in_ready", DG, 64'(in_ready), 64'd1);
      chk("abort_out_valid", DG, 64'(out_valid), 64'd0);
      chk("abort_outputs", DG, 64'({sum, cout, ovf}), 64'd0);
      sb_q.delete();
      seen = 1'b0;
      last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
      step();
      rst = 1'b0;
      step();
      issue(16'h0001, 16'h0001, 1'b0, 1'b0);
      wait_done();

      for (int i = 0; i < 1000; i++) begin
        repeat ($urandom_range(0, 2)) step();
        issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      end
      wait_done();
      fin = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(g[0].fin && g[1].fin && g[2].fin) && t < 95000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 95000) begin
      n_checks++;
      $display("FAIL global_timeout: not all streams finished, expected completion within 95000 cycles");
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
